// File: rtl/sirv_gnrl_pkg.sv
// Shared helpers for the general-purpose library: width calculations
// for pointers and occupancy counters.
package sirv_gnrl_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width: indexes 0..dp-1, never narrower than one bit.
    function automatic int ptr_w(input int dp);
        return (clog2(dp) < 1) ? 1 : clog2(dp);
    endfunction

    // Occupancy width: holds 0..dp inclusive.
    function automatic int cnt_w(input int dp);
        return (clog2(dp + 1) < 1) ? 1 : clog2(dp + 1);
    endfunction

endpackage

// File: rtl/sirv_gnrl_fifo_lr_if.sv
// Valid/ready stream bundle around the FIFO: producer side (i_*),
// consumer side (o_*) and the occupancy count.
interface sirv_gnrl_fifo_lr_if #(
    parameter int DW = 32,
    parameter int DP = 4
);
    import sirv_gnrl_pkg::*;

    localparam int CW = cnt_w(DP);

    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [CW-1:0] cnt;

    modport master (
        output i_vld, i_dat, o_rdy,
        input  i_rdy, o_vld, o_dat, cnt
    );

    modport slave (
        input  i_vld, i_dat, o_rdy,
        output i_rdy, o_vld, o_dat, cnt
    );
endinterface

// File: rtl/sirv_gnrl_dfflr.sv
// Flop primitive with load enable and asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Capture dnxt only when loaded; clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) qout <= '0;
        else if (lden) qout <= dnxt;
    end

endmodule

// File: rtl/sirv_gnrl_fifo_lr.sv
// Parameterised valid/ready FIFO built entirely from sirv_gnrl_dfflr.
// Optional macro SIRV_GNRL_FIFO_BYPASS_EN: when empty, the input beat is
// presented on the output combinationally and, if taken at once, never
// written into storage.
module sirv_gnrl_fifo_lr
    import sirv_gnrl_pkg::*;
#(
    parameter int DP = 4,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    sirv_gnrl_fifo_lr_if.slave  bus
);

    localparam int PW = ptr_w(DP);
    localparam int CW = cnt_w(DP);

    logic [PW-1:0] rptr_q, wptr_q, rptr_nxt, wptr_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          push, pop, full, empty;
    logic [DP-1:0] ent_ld;
    logic [DW-1:0] ent_q [DP];
    logic [DW-1:0] head;

    assign full  = (cnt_q == CW'(DP));
    assign empty = (cnt_q == '0);

    // Ready depends on registered occupancy only, so a full FIFO
    // refuses a beat even in a cycle that pops.
    assign bus.i_rdy = ~full;
    assign bus.cnt   = cnt_q;

`ifdef SIRV_GNRL_FIFO_BYPASS_EN
    logic byp;
    assign byp       = empty & bus.i_vld & bus.o_rdy;
    assign bus.o_vld = ~empty | bus.i_vld;
    assign bus.o_dat = (empty & bus.i_vld) ? bus.i_dat : head;
    assign push      = bus.i_vld & ~full & ~byp;
    assign pop       = ~empty & bus.o_rdy;
`else
    assign bus.o_vld = ~empty;
    assign bus.o_dat = head;
    assign push      = bus.i_vld & ~full;
    assign pop       = ~empty & bus.o_rdy;
`endif

    // Pointers wrap at DP-1 explicitly; DP need not be a power of two.
    assign rptr_nxt = (rptr_q == PW'(DP - 1)) ? '0 : rptr_q + PW'(1);
    assign wptr_nxt = (wptr_q == PW'(DP - 1)) ? '0 : wptr_q + PW'(1);
    assign cnt_nxt  = push ? cnt_q + CW'(1) : cnt_q - CW'(1);

    // Head-of-queue mux; rptr values at or above DP never occur.
    always_comb begin
        head = '0;
        for (int i = 0; i < DP; i++) begin
            if (rptr_q == PW'(i)) head = ent_q[i];
        end
    end

    for (genvar i = 0; i < DP; i++) begin : g_ent
        assign ent_ld[i] = push & (wptr_q == PW'(i));

        sirv_gnrl_dfflr #(.DW(DW)) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .lden  (ent_ld[i]),
            .dnxt  (bus.i_dat),
            .qout  (ent_q[i])
        );
    end

    sirv_gnrl_dfflr #(.DW(PW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (pop),
        .dnxt  (rptr_nxt),
        .qout  (rptr_q)
    );

    sirv_gnrl_dfflr #(.DW(PW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (push),
        .dnxt  (wptr_nxt),
        .qout  (wptr_q)
    );

    // Count moves only when exactly one of push/pop happens.
    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (push ^ pop),
        .dnxt  (cnt_nxt),
        .qout  (cnt_q)
    );

endmodule

// File: tb/tb_sirv_gnrl_fifo_lr.sv
// Bench for sirv_gnrl_fifo_lr: DP=4 instance (directed table, streaming,
// mid-stream reset, bypass) and DP=3 instance (random traffic), both
// checked against a queue model of the FIFO.
module tb_sirv_gnrl_fifo_lr;

    localparam int DW = 32;
`ifdef SIRV_GNRL_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sirv_gnrl_fifo_lr_if #(.DW(DW), .DP(4)) bus_a ();
    sirv_gnrl_fifo_lr_if #(.DW(DW), .DP(3)) bus_b ();

    sirv_gnrl_fifo_lr #(.DP(4), .DW(DW)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sirv_gnrl_fifo_lr #(.DP(3), .DW(DW)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [31:0] e_odat;
        int          e_cnt;
    } vec_t;

    vec_t tbl[11];

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] out_a[$];
    bit          stall[2];
    logic [31:0] stall_dat[2];
    bit          hold[2];
    logic [31:0] hold_dat[2];
    int          max_cnt_b = 0;
    int          pops_b = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        for (int s = 0; s < 2; s++) begin
            stall[s] = 0;
            hold[s]  = 0;
        end
    endtask

    // One clock cycle on FIFO sel: drive, check against the queue model,
    // take the edge, update the model.
    task automatic apply(input int sel, input logic iv, input logic [31:0] id,
                         input logic ordy, output bit acc);
        logic [31:0] q[$];
        logic        a_irdy, a_ovld;
        logic [31:0] a_odat;
        int          a_cnt, dp;
        bit          e_irdy, e_ovld, bypass_beat, do_push, do_pop;
        logic [31:0] e_odat;
        string       t;

        if (sel == 0) begin
            bus_a.i_vld = iv; bus_a.i_dat = id; bus_a.o_rdy = ordy;
            q = qa; dp = 4; t = "A";
        end else begin
            bus_b.i_vld = iv; bus_b.i_dat = id; bus_b.o_rdy = ordy;
            q = qb; dp = 3; t = "B";
        end
        #1;
        if (sel == 0) begin
            a_irdy = bus_a.i_rdy; a_ovld = bus_a.o_vld; a_odat = bus_a.o_dat; a_cnt = int'(bus_a.cnt);
        end else begin
            a_irdy = bus_b.i_rdy; a_ovld = bus_b.o_vld; a_odat = bus_b.o_dat; a_cnt = int'(bus_b.cnt);
            if (a_cnt > max_cnt_b) max_cnt_b = a_cnt;
        end

        if (hold[sel]) begin
            cmp({t, "_prod_hold_vld"}, 32'(iv), 32'd1);
            cmp({t, "_prod_hold_dat"}, id, hold_dat[sel]);
        end
        if (stall[sel]) begin
            cmp({t, "_fifo_hold_vld"}, 32'(a_ovld), 32'd1);
            cmp({t, "_fifo_hold_dat"}, a_odat, stall_dat[sel]);
        end

        e_irdy = (q.size() != dp);
        e_ovld = (q.size() != 0) || (BYP && iv);
        e_odat = (q.size() != 0) ? q[0] : id;
        cmp({t, "_i_rdy"}, 32'(a_irdy), 32'(e_irdy));
        cmp({t, "_o_vld"}, 32'(a_ovld), 32'(e_ovld));
        cmp({t, "_cnt"}, a_cnt, q.size());
        if (e_ovld) cmp({t, "_o_dat"}, a_odat, e_odat);

        bypass_beat = BYP && (q.size() == 0) && iv && ordy;
        do_push = iv && e_irdy && !bypass_beat;
        do_pop  = ordy && (q.size() != 0);
        acc = iv && e_irdy;
        hold[sel] = iv && !e_irdy;
        hold_dat[sel] = id;
        stall[sel] = e_ovld && !ordy;
        stall_dat[sel] = e_odat;
        if (sel == 0 && e_ovld && ordy) out_a.push_back(e_odat);
        if (sel == 1 && e_ovld && ordy) pops_b++;

        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(id);
        if (sel == 0) qa = q; else qb = q;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        logic        r_iv;
        logic [31:0] r_id;

        bus_a.i_vld = 0; bus_a.i_dat = '0; bus_a.o_rdy = 0;
        bus_b.i_vld = 0; bus_b.i_dat = '0; bus_b.o_rdy = 0;
        clear_model();

        // Reset then idle.
        repeat (3) @(negedge clk);
        cmp("rst_i_rdy", 32'(bus_a.i_rdy), 32'd1);
        cmp("rst_o_vld", 32'(bus_a.o_vld), 32'd0);
        cmp("rst_cnt",   32'(bus_a.cnt),   32'd0);
        cmp("rst_o_dat", bus_a.o_dat,      32'd0);
        cmp("rst_b_i_rdy", 32'(bus_b.i_rdy), 32'd1);
        rst_n = 1'b1;

        // Fill to full, offer a fifth word, pop-only while full, drain.
        //          iv id     ordy irdy ovld odat   cnt
        tbl[0]  = '{1, 32'h11, 0, 1, BYP, 32'h11, 0};
        tbl[1]  = '{1, 32'h22, 0, 1, 1,   32'h11, 1};
        tbl[2]  = '{1, 32'h33, 0, 1, 1,   32'h11, 2};
        tbl[3]  = '{1, 32'h44, 0, 1, 1,   32'h11, 3};
        tbl[4]  = '{1, 32'h55, 0, 0, 1,   32'h11, 4};
        tbl[5]  = '{1, 32'h55, 1, 0, 1,   32'h11, 4};
        tbl[6]  = '{1, 32'h55, 1, 1, 1,   32'h22, 3};
        tbl[7]  = '{0, 32'h00, 1, 1, 1,   32'h33, 3};
        tbl[8]  = '{0, 32'h00, 1, 1, 1,   32'h44, 2};
        tbl[9]  = '{0, 32'h00, 1, 1, 1,   32'h55, 1};
        tbl[10] = '{0, 32'h00, 1, 1, 0,   32'h00, 0};
        for (int i = 0; i < 11; i++) begin
            bus_a.i_vld = tbl[i].iv; bus_a.i_dat = tbl[i].id; bus_a.o_rdy = tbl[i].ordy;
            #1;
            cmp($sformatf("tbl%0d_i_rdy", i), 32'(bus_a.i_rdy), 32'(tbl[i].e_irdy));
            cmp($sformatf("tbl%0d_o_vld", i), 32'(bus_a.o_vld), 32'(tbl[i].e_ovld));
            cmp($sformatf("tbl%0d_cnt", i),   32'(bus_a.cnt),   tbl[i].e_cnt);
            if (tbl[i].e_ovld) cmp($sformatf("tbl%0d_o_dat", i), bus_a.o_dat, tbl[i].e_odat);
            apply(0, tbl[i].iv, tbl[i].id, tbl[i].ordy, acc);
        end

        // Continuous streaming of 20 words, both sides always ready.
        out_a.delete();
        for (int k = 0; k < 20; k++) begin
            apply(0, 1'b1, 32'(k), 1'b1, acc);
            cmp($sformatf("stream_acc%0d", k), 32'(acc), 32'd1);
        end
        apply(0, 1'b0, 32'd0, 1'b1, acc);
        apply(0, 1'b0, 32'd0, 1'b1, acc);
        cmp("stream_count", out_a.size(), 32'd20);
        for (int k = 0; k < 20 && k < out_a.size(); k++)
            cmp($sformatf("stream_word%0d", k), out_a[k], 32'(k));

        // Random traffic on the DP=3 instance.
        r_iv = 0; r_id = '0;
        for (int c = 0; c < 1000; c++) begin
            if (!hold[1]) begin
                r_iv = ($urandom_range(0, 3) != 0);
                r_id = $urandom;
            end
            apply(1, r_iv, r_id, ($urandom_range(0, 99) < ((c < 500) ? 35 : 70)), acc);
        end
        apply(1, 1'b0, 32'd0, 1'b1, acc);
        cmp("rand_max_cnt_le3", 32'(max_cnt_b <= 3), 32'd1);
        cmp("rand_reached_full", 32'(max_cnt_b), 32'd3);
        cmp("rand_popped_some", 32'(pops_b > 100), 32'd1);

        // Asynchronous reset mid-stream with two entries held.
        apply(0, 1'b1, 32'hA1, 1'b0, acc);
        apply(0, 1'b1, 32'hA2, 1'b0, acc);
        bus_a.i_vld = 0; bus_a.o_rdy = 0;
        #1;
        cmp("pre_rst_cnt", 32'(bus_a.cnt), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("midrst_i_rdy", 32'(bus_a.i_rdy), 32'd1);
        cmp("midrst_o_vld", 32'(bus_a.o_vld), 32'd0);
        cmp("midrst_cnt",   32'(bus_a.cnt),   32'd0);
        cmp("midrst_o_dat", bus_a.o_dat,      32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 1'b1, 32'h77, 1'b0, acc);
        bus_a.i_vld = 0;
        #1;
        cmp("postrst_o_vld", 32'(bus_a.o_vld), 32'd1);
        cmp("postrst_o_dat", bus_a.o_dat,      32'h77);
        cmp("postrst_cnt",   32'(bus_a.cnt),   32'd1);
        apply(0, 1'b0, 32'd0, 1'b1, acc);
        apply(0, 1'b0, 32'd0, 1'b1, acc);

`ifdef SIRV_GNRL_FIFO_BYPASS_EN
        // Empty FIFO passes a beat straight through.
        bus_a.i_vld = 1; bus_a.i_dat = 32'hAB; bus_a.o_rdy = 1;
        #1;
        cmp("byp_o_vld", 32'(bus_a.o_vld), 32'd1);
        cmp("byp_o_dat", bus_a.o_dat,      32'hAB);
        cmp("byp_cnt",   32'(bus_a.cnt),   32'd0);
        apply(0, 1'b1, 32'hAB, 1'b1, acc);
        bus_a.i_vld = 0;
        #1;
        cmp("byp_cnt_after", 32'(bus_a.cnt), 32'd0);
        cmp("byp_o_vld_after", 32'(bus_a.o_vld), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
